// File: rtl/uart_pkg.sv
// Types and constants shared by the UART word send path: the serialiser FSM
// states and the word/byte geometry.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, SEND, GAP} send_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;
   localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD + 1);

   // Most significant byte of a word; bytes leave the serialiser MSB first.
   function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w);
      return w[WORD_W-1 -: BYTE_W];
   endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with registered pointers, registered count/full and
// first-word-fall-through read data.
module sync_word_fifo #(
   parameter int DEPTH_LOG = 4
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [31:0]          din,
   output logic [31:0]          dout,
   output logic [DEPTH_LOG:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] DEPTH_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

   logic [31:0]          mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic                 full_q, full_d;
   logic                 do_push, do_pop;

   // A push while full is refused even if a pop happens in the same cycle.
   assign do_push = push && !full_q;
   assign do_pop  = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d = (count_d == DEPTH_CNT);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/word_send_queue.sv
// Queues 32-bit words from the pipeline and serialises each one, MSB first,
// into byte strobes for the byte-level UART sender.
module word_send_queue
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG = 4
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [31:0]          word_in,
   input  logic                 word_valid,
   output logic                 full,
   output logic [DEPTH_LOG:0]   count,
   output logic [BYTE_W-1:0]    byte_data,
   output logic                 byte_enable,
   input  logic                 byte_ready,
   output logic                 idle,
   output logic                 overflow
);

   send_state_e        state_q, state_d;
   logic [WORD_W-1:0]  sh_q, sh_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               overflow_q, overflow_d;

   logic [31:0]        fifo_dout;
   logic               fifo_empty;
   logic               fifo_pop;

   sync_word_fifo #(
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .CLK   (CLK),
      .reset (reset),
      .push  (word_valid),
      .pop   (fifo_pop),
      .din   (word_in),
      .dout  (fifo_dout),
      .count (count),
      .full  (full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      idx_d       = idx_q;
      fifo_pop    = 1'b0;
      byte_enable = 1'b0;
      overflow_d  = overflow_q | (word_valid & full);
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sh_d     = fifo_dout;
               idx_d    = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            byte_enable = byte_ready;
            if (byte_ready) begin
               sh_d    = {sh_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               idx_d   = idx_q + 1'b1;
               state_d = GAP;
            end
         end
         // One dead cycle lets the sender drop byte_ready before the next byte.
         GAP: begin
            state_d = (idx_q == IDX_W'(BYTES_PER_WORD)) ? IDLE : SEND;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= IDLE;
         sh_q       <= '0;
         idx_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
      end
   end

   assign byte_data = head_byte(sh_q);
   assign idle      = (state_q == IDLE) && fifo_empty;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_word_send_queue.sv
// Randomised scoreboard bench for word_send_queue: a queue-based reference
// model predicts FIFO occupancy, flags and the byte stream.
module tb_word_send_queue;

   localparam int DL    = 4;
   localparam int DEPTH = 2 ** DL;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   word_in = '0;
   logic          word_valid = 1'b0;
   logic          byte_ready = 1'b0;
   logic          full;
   logic [DL:0]   count;
   logic [7:0]    byte_data;
   logic          byte_enable;
   logic          idle;
   logic          overflow;

   word_send_queue #(.DEPTH_LOG(DL)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .full        (full),
      .count       (count),
      .byte_data   (byte_data),
      .byte_enable (byte_enable),
      .byte_ready  (byte_ready),
      .idle        (idle),
      .overflow    (overflow)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int strobes = 0;

   // Reference model: words waiting, bytes left in the word being sent,
   // and a one-cycle hold after each byte.
   logic [31:0] mq[$];
   logic [7:0]  ser[$];
   logic [7:0]  sb[$];
   int          hold = 0;
   bit          m_ovf = 1'b0;
   bit          m_fresh = 1'b1;
   bit          m_acc;
   logic [31:0] m_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      if (reset) begin
         mq.delete();
         ser.delete();
         sb.delete();
         hold    = 0;
         m_ovf   = 1'b0;
         m_fresh = 1'b1;
      end else begin
         m_acc = 1'b0;
         if (word_valid) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else m_acc = 1'b1;
         end
         if (ser.size() == 0 && hold == 0) begin
            if (mq.size() != 0) begin
               m_w = mq.pop_front();
               for (int b = 0; b < 4; b++) ser.push_back(m_w[31-8*b -: 8]);
               m_fresh = 1'b0;
            end
         end else if (hold != 0) begin
            hold = 0;
         end else if (byte_ready) begin
            void'(ser.pop_front());
            hold = 1;
         end
         if (m_acc) begin
            mq.push_back(word_in);
            for (int b = 0; b < 4; b++) sb.push_back(word_in[31-8*b -: 8]);
         end
      end
   end

   // Monitor: flags against the model each cycle, strobed bytes against the scoreboard.
   always @(negedge CLK) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("idle", 32'(idle), 32'(ser.size() == 0 && hold == 0 && mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("byte_enable", 32'(byte_enable),
          32'(ser.size() != 0 && hold == 0 && byte_ready == 1'b1));
      if (ser.size() != 0 && hold == 0)
         chk("byte_data_send", 32'(byte_data), 32'(ser[0]));
      else if (m_fresh)
         chk("byte_data_reset", 32'(byte_data), 32'h0);
      if (byte_enable === 1'b1) begin
         strobes++;
         if (sb.size() == 0) chk("unexpected_strobe", 32'(byte_data), 32'hFFFF_FFFF);
         else chk("byte_stream", 32'(byte_data), 32'(sb.pop_front()));
      end
   end

   task automatic step(input logic wv, input logic [31:0] w, input logic rdy, input logic rst);
      @(posedge CLK);
      #1;
      word_valid = wv;
      word_in    = w;
      byte_ready = rdy;
      reset      = rst;
   endtask

   initial begin
      int s0;
      repeat (3) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);

      // Single word with an always-ready sender.
      step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      repeat (14) step(1'b0, '0, 1'b1, 1'b0);

      // Fill while the sender is stalled; the last pushes overflow.
      for (int i = 1; i <= 18; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
      repeat (2) step(1'b0, '0, 1'b0, 1'b0);

      // Keep pushing while draining: pops from a full queue race pushes.
      for (int i = 0; i < 40; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      repeat (200) step(1'b0, '0, 1'b1, 1'b0);

      // Slow sender: 3 cycles busy, 1 ready.
      step(1'b1, 32'h01020304, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, '0, (i % 4) == 3, 1'b0);
      repeat (5) step(1'b0, '0, 1'b1, 1'b0);

      // Reset after the second byte of a word with three more queued.
      step(1'b1, 32'h11111111, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      s0 = strobes;
      step(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
      step(1'b1, $urandom, 1'b1, 1'b0);
      step(1'b1, $urandom, 1'b1, 1'b0);
      step(1'b1, $urandom, 1'b1, 1'b0);
      for (int k = 0; k < 30 && strobes < s0 + 2; k++) step(1'b0, '0, 1'b1, 1'b0);
      if (strobes < s0 + 2) chk("wait_two_strobes", 32'(strobes - s0), 32'd2);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 32'h11223344, 1'b1, 1'b0);
      repeat (14) step(1'b0, '0, 1'b1, 1'b0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 70,
              $urandom_range(0, 599) == 0);
      end
      repeat (300) step(1'b0, '0, 1'b1, 1'b0);

      @(negedge CLK);
      chk("drain_scoreboard", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
